// File: rtl/seq_det_ctrl_pkg.sv
// Shared definitions for the serial sequence detector: controller states and
// default sizing.
package seq_det_ctrl_pkg;
  localparam int PAT_MAX_DEF = 8;
  localparam int CNT_W_DEF   = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READY = 2'd1,
    ST_RUN   = 2'd2,
    ST_DONE  = 2'd3
  } state_t;
endpackage

// File: rtl/seq_det_match.sv
// History shift register, fill count and masked pattern compare. The match
// flag is combinational and looks at the history including the incoming bit.
module seq_det_match #(
  parameter int PAT_MAX = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_clear,
  input  logic               i_shift,
  input  logic               i_x,
  input  logic [PAT_MAX-1:0] i_pattern,
  input  logic [3:0]         i_len,
  input  logic               i_overlap,
  output logic               o_match
);
  localparam int FILL_W = $clog2(PAT_MAX + 1);
  localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(PAT_MAX);

  logic [PAT_MAX-1:0] r_hist;
  logic [FILL_W-1:0]  r_fill;
  logic [PAT_MAX-1:0] w_hist_next;
  logic [FILL_W-1:0]  w_fill_next;
  logic [PAT_MAX-1:0] w_mask;
  logic               w_len_ok;

  assign w_hist_next = {r_hist[PAT_MAX-2:0], i_x};
  assign w_fill_next = (r_fill == FILL_MAX) ? r_fill : r_fill + 1'b1;

  // Only the low i_len bits take part in the compare.
  generate
    for (genvar gi = 0; gi < PAT_MAX; gi++) begin : g_mask
      assign w_mask[gi] = (i_len > 4'(gi));
    end
  endgenerate

  assign w_len_ok = (32'(w_fill_next) >= 32'(i_len));
  assign o_match  = i_shift && w_len_ok &&
                    (((w_hist_next ^ i_pattern) & w_mask) == '0);

  always_ff @(posedge clk) begin
    if (!rst || i_clear) begin
      r_hist <= '0;
      r_fill <= '0;
    end else if (i_shift) begin
      r_hist <= w_hist_next;
      // Non-overlapping mode restarts the window after each hit.
      r_fill <= (o_match && !i_overlap) ? '0 : w_fill_next;
    end
  end
endmodule

// File: rtl/seq_det_ctrl.sv
// Configurable serial pattern detector: configure once from IDLE, then arm
// with start; counts matches until target, stop or reset.
module seq_det_ctrl
  import seq_det_ctrl_pkg::*;
#(
  parameter int PAT_MAX = PAT_MAX_DEF,
  parameter int CNT_W   = CNT_W_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cfg_valid,
  output logic               cfg_ready,
  input  logic [PAT_MAX-1:0] cfg_pattern,
  input  logic [3:0]         cfg_len,
  input  logic               cfg_overlap,
  input  logic [CNT_W-1:0]   cfg_target,
  input  logic               start,
  input  logic               stop,
  input  logic               x,
  input  logic               x_valid,
  output logic               y,
  output logic [CNT_W-1:0]   match_cnt,
  output logic               busy,
  output logic               done,
  output logic               cfg_err
);
  state_t             r_state, w_state_next;
  logic [PAT_MAX-1:0] r_pattern, w_pattern_next;
  logic [3:0]         r_len, w_len_next;
  logic               r_overlap, w_overlap_next;
  logic [CNT_W-1:0]   r_target, w_target_next;
  logic [CNT_W-1:0]   r_cnt, w_cnt_next;
  logic               r_y, w_y_next;
  logic               r_cfg_err, w_cfg_err_next;

  logic               w_len_legal;
  logic               w_clear;
  logic               w_shift;
  logic               w_match;
  logic [CNT_W-1:0]   w_cnt_inc;

  assign w_len_legal = (cfg_len != 4'd0) && (32'(cfg_len) <= PAT_MAX);
  assign w_clear     = start && ((r_state == ST_READY) || (r_state == ST_DONE));
  assign w_shift     = x_valid && (r_state == ST_RUN);
  assign w_cnt_inc   = (&r_cnt) ? r_cnt : r_cnt + 1'b1;

  seq_det_match #(.PAT_MAX(PAT_MAX)) u_match (
    .clk       (clk),
    .rst       (rst),
    .i_clear   (w_clear),
    .i_shift   (w_shift),
    .i_x       (x),
    .i_pattern (r_pattern),
    .i_len     (r_len),
    .i_overlap (r_overlap),
    .o_match   (w_match)
  );

  always_comb begin
    w_state_next   = r_state;
    w_pattern_next = r_pattern;
    w_len_next     = r_len;
    w_overlap_next = r_overlap;
    w_target_next  = r_target;
    w_cnt_next     = r_cnt;
    w_y_next       = 1'b0;
    w_cfg_err_next = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (cfg_valid) begin
          if (w_len_legal) begin
            w_pattern_next = cfg_pattern;
            w_len_next     = cfg_len;
            w_overlap_next = cfg_overlap;
            w_target_next  = cfg_target;
            w_state_next   = ST_READY;
          end else begin
            w_cfg_err_next = 1'b1;
          end
        end
      end
      ST_READY, ST_DONE: begin
        if (start) begin
          w_cnt_next   = '0;
          w_state_next = ST_RUN;
        end
      end
      ST_RUN: begin
        if (w_match) begin
          w_y_next   = 1'b1;
          w_cnt_next = w_cnt_inc;
        end
        // stop takes priority over the target exit, but the hit is still counted.
        if (stop) begin
          w_state_next = ST_DONE;
        end else if (w_match && (r_target != '0) && (w_cnt_inc == r_target)) begin
          w_state_next = ST_DONE;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state   <= ST_IDLE;
      r_pattern <= '0;
      r_len     <= '0;
      r_overlap <= 1'b0;
      r_target  <= '0;
      r_cnt     <= '0;
      r_y       <= 1'b0;
      r_cfg_err <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_pattern <= w_pattern_next;
      r_len     <= w_len_next;
      r_overlap <= w_overlap_next;
      r_target  <= w_target_next;
      r_cnt     <= w_cnt_next;
      r_y       <= w_y_next;
      r_cfg_err <= w_cfg_err_next;
    end
  end

  assign cfg_ready = (r_state == ST_IDLE);
  assign busy      = (r_state == ST_RUN);
  assign done      = (r_state == ST_DONE);
  assign y         = r_y;
  assign match_cnt = r_cnt;
  assign cfg_err   = r_cfg_err;
endmodule

// File: tb/tb_seq_det_ctrl.sv
// Self-checking bench: directed scenarios with literal expectations plus
// randomized traffic compared every cycle against a queue-based model.
module tb_seq_det_ctrl;
  logic       clk = 1'b0;
  logic       rst;
  logic       cfg_valid;
  logic       cfg_ready;
  logic [7:0] cfg_pattern;
  logic [3:0] cfg_len;
  logic       cfg_overlap;
  logic [7:0] cfg_target;
  logic       start;
  logic       stop;
  logic       x;
  logic       x_valid;
  logic       y;
  logic [7:0] match_cnt;
  logic       busy;
  logic       done;
  logic       cfg_err;

  int checks = 0;
  int errors = 0;
  int ycnt   = 0;

  seq_det_ctrl #(.PAT_MAX(8), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_pattern(cfg_pattern), .cfg_len(cfg_len), .cfg_overlap(cfg_overlap),
    .cfg_target(cfg_target), .start(start), .stop(stop), .x(x),
    .x_valid(x_valid), .y(y), .match_cnt(match_cnt), .busy(busy),
    .done(done), .cfg_err(cfg_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: mode 0=unconfigured, 1=configured, 2=running, 3=finished.
  int         m_mode;
  bit [7:0]   m_pat;
  int         m_len, m_target, m_cnt;
  bit         m_ov, m_y, m_err, m_known = 0;
  bit         q[$];
  bit         hit;

  always @(posedge clk) begin
    if (!rst) begin
      m_mode = 0; m_pat = 0; m_len = 0; m_ov = 0; m_target = 0;
      m_cnt = 0; m_y = 0; m_err = 0; q.delete(); m_known = 1;
    end else if (m_known) begin
      m_y = 0; m_err = 0;
      case (m_mode)
        0: if (cfg_valid) begin
             if (cfg_len >= 1 && cfg_len <= 8) begin
               m_pat = cfg_pattern; m_len = cfg_len; m_ov = cfg_overlap;
               m_target = cfg_target; m_mode = 1;
             end else m_err = 1;
           end
        1, 3: if (start) begin m_mode = 2; m_cnt = 0; q.delete(); end
        2: begin
             hit = 0;
             if (x_valid) begin
               q.push_back(x);
               if (q.size() > 8) void'(q.pop_front());
               if (q.size() >= m_len) begin
                 hit = 1;
                 for (int i = 0; i < m_len; i++)
                   if (q[q.size() - 1 - i] != m_pat[i]) hit = 0;
               end
               if (hit) begin
                 m_y = 1;
                 if (m_cnt < 255) m_cnt++;
                 if (!m_ov) q.delete();
               end
             end
             if (stop) m_mode = 3;
             else if (hit && m_target != 0 && m_cnt == m_target) m_mode = 3;
           end
        default: m_mode = 0;
      endcase
    end
    #1;
    if (m_known) begin
      chk("cfg_ready", int'(cfg_ready), int'(m_mode == 0));
      chk("busy",      int'(busy),      int'(m_mode == 2));
      chk("done",      int'(done),      int'(m_mode == 3));
      chk("y",         int'(y),         int'(m_y));
      chk("cfg_err",   int'(cfg_err),   int'(m_err));
      chk("match_cnt", int'(match_cnt), m_cnt);
      if (y) ycnt++;
    end
  end

  task automatic do_reset();
    rst = 1'b0; @(negedge clk); rst = 1'b1;
  endtask

  task automatic cfg(input logic [7:0] p, input logic [3:0] l, input logic ov,
                     input logic [7:0] t);
    cfg_valid = 1'b1; cfg_pattern = p; cfg_len = l; cfg_overlap = ov; cfg_target = t;
    @(negedge clk); cfg_valid = 1'b0;
  endtask

  task automatic start_pulse();
    start = 1'b1; @(negedge clk); start = 1'b0;
  endtask

  task automatic send(input logic b);
    x = b; x_valid = 1'b1; @(negedge clk); x_valid = 1'b0;
  endtask

  task automatic setup(input logic [7:0] p, input logic [3:0] l, input logic ov,
                       input logic [7:0] t);
    do_reset(); cfg(p, l, ov, t); start_pulse();
  endtask

  int        ybase;
  bit [7:0]  stream;

  initial begin
    rst = 1'b0; cfg_valid = 0; cfg_pattern = 0; cfg_len = 0; cfg_overlap = 0;
    cfg_target = 0; start = 0; stop = 0; x = 0; x_valid = 0;
    repeat (2) @(negedge clk);
    chk("rst_cfg_ready", int'(cfg_ready), 1);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_match_cnt", int'(match_cnt), 0);
    rst = 1'b1;

    // Overlapping 101 on 0,1,1,1,0,1,0,1
    stream = 8'b01110101;
    setup(8'b101, 4'd3, 1'b1, 8'd0); ybase = ycnt;
    for (int i = 7; i >= 0; i--) send(stream[i]);
    chk("ovl_pulses", ycnt - ybase, 2);
    chk("ovl_cnt", int'(match_cnt), 2);
    stop = 1'b1; @(negedge clk); stop = 1'b0;
    chk("stop_done", int'(done), 1);
    chk("stop_cnt_held", int'(match_cnt), 2);

    // Same stream, non-overlapping
    setup(8'b101, 4'd3, 1'b0, 8'd0); ybase = ycnt;
    for (int i = 7; i >= 0; i--) send(stream[i]);
    chk("novl_pulses", ycnt - ybase, 1);
    chk("novl_cnt", int'(match_cnt), 1);

    // Pattern 11, target 3
    setup(8'b11, 4'd2, 1'b1, 8'd3); ybase = ycnt;
    for (int i = 0; i < 4; i++) send(1'b1);
    chk("tgt_pulses", ycnt - ybase, 3);
    chk("tgt_cnt", int'(match_cnt), 3);
    chk("tgt_done", int'(done), 1);

    // Illegal lengths
    do_reset();
    cfg(8'b101, 4'd0, 1'b1, 8'd0);
    chk("len0_err", int'(cfg_err), 1);
    chk("len0_ready", int'(cfg_ready), 1);
    cfg(8'b101, 4'd9, 1'b1, 8'd0);
    chk("len9_err", int'(cfg_err), 1);
    start_pulse();
    chk("len9_nostart", int'(busy), 0);
    chk("len9_ready", int'(cfg_ready), 1);

    // Gapped x_valid
    setup(8'b101, 4'd3, 1'b1, 8'd0); ybase = ycnt;
    send(1'b1); @(negedge clk); send(1'b0); @(negedge clk); send(1'b1);
    chk("gap_pulses", ycnt - ybase, 1);

    // Reset mid-run
    setup(8'b101, 4'd3, 1'b1, 8'd0);
    send(1'b1); send(1'b0);
    do_reset();
    chk("mid_rst_busy", int'(busy), 0);
    chk("mid_rst_y", int'(y), 0);
    chk("mid_rst_cnt", int'(match_cnt), 0);
    chk("mid_rst_ready", int'(cfg_ready), 1);
    ybase = ycnt;
    send(1'b1);
    chk("mid_rst_noy", ycnt - ybase, 0);

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      rst         = ($urandom_range(0, 79) != 0);
      cfg_valid   = ($urandom_range(0, 3) == 0);
      cfg_len     = ($urandom_range(0, 5) == 0) ? 4'($urandom_range(0, 15))
                                                : 4'($urandom_range(1, 4));
      cfg_pattern = 8'($urandom);
      cfg_overlap = 1'($urandom);
      cfg_target  = 8'($urandom_range(0, 4));
      start       = ($urandom_range(0, 9) == 0);
      stop        = ($urandom_range(0, 39) == 0);
      x           = 1'($urandom);
      x_valid     = ($urandom_range(0, 3) != 0);
      @(negedge clk);
    end
    rst = 1'b1; cfg_valid = 0; start = 0; stop = 0; x_valid = 0;
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/seq_det_ctrl.md
SEQ_DET_CTRL -- requirements
Module: seq_det_ctrl

Interface
REQ-001 Parameter PAT_MAX, default 8, maximum pattern length in bits.
REQ-002 Parameter CNT_W, default 8, width of the match counter and target.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  reset; one clock, synchronous and active-low (0 = reset).
REQ-005 cfg_valid  input  1  configuration offer.
REQ-006 cfg_ready  output  1  high only in IDLE; transfer when cfg_valid&&cfg_ready.
REQ-007 cfg_pattern  input  PAT_MAX  pattern bits; bit 0 = last-received bit.
REQ-008 cfg_len  input  4  pattern length, legal 1..PAT_MAX.
REQ-009 cfg_overlap  input  1  1 = overlapping detection, 0 = non-overlapping.
REQ-010 cfg_target  input  CNT_W  matches before DONE; 0 = run until stop.
REQ-011 start  input  1  single-cycle arm request.
REQ-012 stop  input  1  single-cycle abort request.
REQ-013 x  input  1  serial data bit.
REQ-014 x_valid  input  1  x sampled only when high.
REQ-015 y  output  1  registered one-cycle match pulse.
REQ-016 match_cnt  output  CNT_W  matches since start.
REQ-017 busy  output  1  high in RUN.
REQ-018 done  output  1  high in DONE.
REQ-019 cfg_err  output  1  one-cycle pulse on an illegal configuration.

Function
REQ-020 FSM states: IDLE, READY, RUN, DONE, held in a state register.
REQ-021 IDLE: accepted config with legal cfg_len -> READY; illegal cfg_len (0 or >PAT_MAX) -> cfg_err pulse, stay IDLE, config not stored.
REQ-022 READY: start -> RUN, clearing history, fill count and match_cnt; a cfg_valid here is ignored (cfg_ready=0).
REQ-023 RUN: each x_valid cycle shifts x into history bit 0 and increments fill count, saturating at PAT_MAX.
REQ-024 Match when fill count >= len and low len history bits (including the new bit) equal low len pattern bits.
REQ-025 y is high the cycle after the completing x_valid edge; latency is 1 clock; never high outside RUN except that final pulse.
REQ-026 On match: match_cnt += 1, saturating at all-ones; if cfg_overlap=0, fill count resets to 0.
REQ-027 If target != 0 and match_cnt reaches target, go to DONE on the same edge as the match; y still pulses.
REQ-028 stop in RUN -> DONE with match_cnt held; stop in any other state is ignored; stop wins over a simultaneous match's state change, but the match is still counted.
REQ-029 DONE: match_cnt held; start -> RUN, same config, counters cleared; cfg_valid accepted only after return to IDLE.
REQ-030 DONE or READY: cfg_valid with legal cfg_len is not taken; 1-cycle clear request is not defined; the block returns to IDLE only by reset.
REQ-031 x_valid=0 cycles leave history, fill count and y unchanged (y=0).

Reset
REQ-032 rst=0 at an edge forces IDLE, clears history, fill count, match_cnt and config; y, busy, done and cfg_err are 0; cfg_ready=1 from the next cycle.
REQ-033 Reset mid-RUN discards partial matches; no y pulse follows.

Structure
REQ-034 A shared package holds the state enum and PAT_MAX/CNT_W defaults.
REQ-035 One sub-module, seq_det_match: history shift register, fill count and compare, producing a combinational match flag.

Verification
REQ-036 Pattern 101, len 3, overlap 1, target 0; x = 0,1,1,1,0,1,0,1 -> y pulses after bits 6 and 8, match_cnt=2.
REQ-037 Same stream with overlap 0 -> a single y pulse after bit 6, match_cnt=1.
REQ-038 Pattern 11, len 2, target 3; x = 1,1,1,1 -> y pulses after bits 2, 3 and 4; done=1 after bit 4, match_cnt=3.
REQ-039 cfg_len=0 or 9 -> cfg_err pulse, cfg_ready stays 1, start has no effect.
REQ-040 x_valid toggling 1,0,1,0,1 with x=1,-,0,-,1 and pattern 101 -> one y pulse after the fifth cycle.
REQ-041 rst=0 asserted mid-RUN after bits 1,0 -> all outputs 0; after release, bit 1 gives no y.
